reg_file_mp: RTL

- Parametrised successor to the CPU's two-read/one-write register file, used in the decode stage of the 5-stage pipeline.
- Provides NUM_RD combinational read ports and two GPR write ports: port 0 is the ALU/load writeback, port 1 is the late-result writeback.
- Has dedicated HI/LO registers with a 64-bit write port.
- A per-register busy scoreboard lets decode detect pending producers, including multi-cycle multiply/divide results.

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/reg_file_mp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and a slice helper for the multi-port register file.
// The RF_BYPASS_EN build option is handled in reg_file_mp.
package rf_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int REG_ZERO     = 0;
    localparam int HILO_W       = 2 * RF_DATA_W;

    // Upper bounds for the generic slice helper; they cover up to 4 ports of 64-bit data.
    localparam int RF_MAX_VEC   = 256;
    localparam int RF_MAX_SLICE = 64;

    function automatic logic [RF_MAX_SLICE-1:0] rf_slice(input logic [RF_MAX_VEC-1:0] vec,
                                                         input int idx,
                                                         input int w);
        logic [RF_MAX_VEC-1:0]   shifted;
        logic [RF_MAX_SLICE-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (RF_MAX_SLICE'(1) << w) - RF_MAX_SLICE'(1);
        return RF_MAX_SLICE'(shifted) & mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-GPR busy bits. Each edge applies flush, then write clears, then the issue set,
// so a set always wins over a same-cycle clear or flush of the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 clr0_en_i,
    input  logic [ADDR_W-1:0]    clr0_addr_i,
    input  logic                 clr1_en_i,
    input  logic [ADDR_W-1:0]    clr1_addr_i,
    input  logic                 set_en_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    output logic [2**ADDR_W-1:0] busy_o
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = flush_i ? '0 : busy_q;
        if (clr0_en_i) busy_d[clr0_addr_i] = 1'b0;
        if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
        if (set_en_i && (set_addr_i != ADDR_W'(REG_ZERO))) busy_d[set_addr_i] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Decode-stage register file: NUM_RD read ports, two GPR write ports, HI/LO and a busy
// scoreboard. Defining RF_BYPASS_EN makes same-cycle writes visible on the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       wen1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       hilo_wen,
    input  logic [2*DATA_W-1:0]        hilo_wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    output logic [DATA_W-1:0]          hi_rdata,
    output logic [DATA_W-1:0]          lo_rdata,
    output logic                       hilo_busy,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_addr,
    input  logic                       hilo_set,
    input  logic                       flush
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              hilo_busy_q;
    logic              hilo_busy_d;
    logic [NREG-1:0]   busy;

    // Port 1 is checked first so it wins when both ports target the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wen1 && (waddr1 == ADDR_W'(r)))      regs_q[r] <= wdata1;
                else if (wen0 && (waddr0 == ADDR_W'(r))) regs_q[r] <= wdata0;
            end
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .clr0_en_i  (wen0),
        .clr0_addr_i(waddr0),
        .clr1_en_i  (wen1),
        .clr1_addr_i(waddr1),
        .set_en_i   (set_en),
        .set_addr_i (set_addr),
        .busy_o     (busy)
    );

    always_comb begin
        hilo_busy_d = flush ? 1'b0 : hilo_busy_q;
        if (hilo_wen) hilo_busy_d = 1'b0;
        if (hilo_set) hilo_busy_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_busy_q <= 1'b0;
        end else begin
            if (hilo_wen) begin
                hi_q <= hilo_wdata[2*DATA_W-1:DATA_W];
                lo_q <= hilo_wdata[DATA_W-1:0];
            end
            hilo_busy_q <= hilo_busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              bz;

        assign ra = ADDR_W'(rf_slice(RF_MAX_VEC'(raddr), i, ADDR_W));

        always_comb begin
            rd = '0;
            bz = 1'b0;
            if (ra != ADDR_W'(REG_ZERO)) begin
                rd = regs_q[ra];
                bz = busy[ra];
`ifdef RF_BYPASS_EN
                if (wen0 && (waddr0 == ra)) begin
                    rd = wdata0;
                    bz = 1'b0;
                end
                if (wen1 && (waddr1 == ra)) begin
                    rd = wdata1;
                    bz = 1'b0;
                end
`endif
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
        assign rbusy[i]                  = bz;
    end

    always_comb begin
        hi_rdata  = hi_q;
        lo_rdata  = lo_q;
        hilo_busy = hilo_busy_q;
`ifdef RF_BYPASS_EN
        if (hilo_wen) begin
            hi_rdata  = hilo_wdata[2*DATA_W-1:DATA_W];
            lo_rdata  = hilo_wdata[DATA_W-1:0];
            hilo_busy = 1'b0;
        end
`endif
    end

endmodule
